// File: rtl/dmem_dma_if.sv
// Data-memory bus seen from a DMA initiator: strobes, address and data out,
// arbiter grant and read data in.
interface dmem_dma_if #(
    parameter int WIDTH = 32
);
    logic               bus_gnt;
    logic [WIDTH-1:0]   bus_data_out;
    logic [WIDTH-1:0]   bus_addr_in;
    logic [WIDTH-1:0]   bus_data_in;
    logic [WIDTH/8-1:0] bus_byteen;
    logic               bus_mem_read;
    logic               bus_mem_write;
    logic               bus_req;

    modport master (
        input  bus_gnt,
        input  bus_data_out,
        output bus_addr_in,
        output bus_data_in,
        output bus_byteen,
        output bus_mem_read,
        output bus_mem_write,
        output bus_req
    );

    modport slave (
        output bus_gnt,
        output bus_data_out,
        input  bus_addr_in,
        input  bus_data_in,
        input  bus_byteen,
        input  bus_mem_read,
        input  bus_mem_write,
        input  bus_req
    );
endinterface

// File: rtl/dmem_dma_engine.sv
// Word-copy DMA initiator on the data-memory bus: one read then one write
// per word, strobing only while the arbiter grants the bus.
module dmem_dma_engine #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [LEN_W-1:0] len_words,
    dmem_dma_if.master       bus,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        src_d             = src_q;
        dst_d             = dst_q;
        cnt_d             = cnt_q;
        buf_d             = buf_q;
        err_d             = err_q;
        bus.bus_addr_in   = '0;
        bus.bus_data_in   = '0;
        bus.bus_byteen    = '0;
        bus.bus_mem_read  = 1'b0;
        bus.bus_mem_write = 1'b0;
        bus.bus_req       = 1'b0;
        done              = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    cnt_d = len_words;
                    err_d = 1'b0;
                    if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (len_words == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    bus.bus_mem_read = 1'b1;
                    bus.bus_addr_in  = src_q;
                    buf_d            = bus.bus_data_out;
                    src_d            = src_q + WIDTH'(4);
                    state_d          = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.bus_req = 1'b1;
                // buf_q is held across any grant gap until this write lands
                if (bus.bus_gnt) begin
                    bus.bus_mem_write = 1'b1;
                    bus.bus_byteen    = '1;
                    bus.bus_addr_in   = dst_q;
                    bus.bus_data_in   = buf_q;
                    dst_d             = dst_q + WIDTH'(4);
                    cnt_d             = cnt_q - LEN_W'(1);
                    state_d           = (cnt_q == LEN_W'(1)) ? S_FIN : S_READ;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;
endmodule
